// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock over WIDTH/DIGIT RUN cycles.
// Returns {carry/no-borrow, result} and a two's-complement overflow flag.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] bit1,
  input  logic [WIDTH-1:0] bit2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   final_answer,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_final;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;
  logic [DIGIT-1:0] w_a_dig;
  logic [DIGIT-1:0] w_b_dig;
  logic [DIGIT-1:0] w_sum_dig;
  logic [DIGIT:0]   w_c;
  logic             w_last;
  logic             w_accept;

  assign w_last   = (r_cnt == CW'(N - 1));
  assign w_accept = start && (r_state != RUN);

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DONE: begin
        if (start) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Ripple one digit of A and the (possibly inverted) B through the running carry.
  always_comb begin
    w_a_dig   = r_a[r_cnt*DIGIT +: DIGIT];
    w_b_dig   = r_b[r_cnt*DIGIT +: DIGIT];
    w_sum_dig = '0;
    w_c       = '0;
    w_c[0]    = r_carry;
    for (int k = 0; k < DIGIT; k++) begin
      w_sum_dig[k] = w_a_dig[k] ^ w_b_dig[k] ^ w_c[k];
      w_c[k+1]     = (w_a_dig[k] & w_b_dig[k]) | (w_c[k] & (w_a_dig[k] ^ w_b_dig[k]));
    end
    w_acc_nxt = r_acc;
    w_acc_nxt[r_cnt*DIGIT +: DIGIT] = w_sum_dig;
  end

  // State register and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == RUN);
      r_done  <= (w_state_nxt == DONE);
    end
  end

  // Operand capture, digit accumulation and result latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_final <= '0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is A + ~B + 1: invert B once here and seed the carry with mode.
      r_a     <= bit1;
      r_b     <= bit2 ^ {WIDTH{mode}};
      r_carry <= mode;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_acc   <= w_acc_nxt;
      r_carry <= w_c[DIGIT];
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_final <= {w_c[DIGIT], w_acc_nxt};
        r_ovf   <= w_c[DIGIT] ^ w_c[DIGIT-1];
      end
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign final_answer = r_final;
  assign overflow     = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench: one 8-bit/2-digit instance for directed cases and
// three 4-bit instances (DIGIT=1/2/4) swept exhaustively in parallel.
module tb_serial_addsub;

  typedef struct {
    logic [8:0] ans;
    logic       ovf;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       s8, m8;
  logic [7:0] a8, b8;
  logic       busy8, done8, ovf8;
  logic [8:0] ans8;
  logic       s4, m4;
  logic [3:0] a4, b4;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   run8 = 0;
  exp_t sb8[$];
  exp_t q4[3][$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  serial_addsub #(.WIDTH(8), .DIGIT(2)) u_dut8 (
    .clk(clk), .rst(rst), .start(s8), .mode(m8), .bit1(a8), .bit2(b8),
    .busy(busy8), .done(done8), .final_answer(ans8), .overflow(ovf8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model by sign analysis; returns {ovf, ans[8:0]}.
  function automatic logic [9:0] model(input int w, input int a, input int b, input int m);
    int mask, bb, s, sa, sb, sr;
    mask = (1 << w) - 1;
    bb   = (m != 0) ? ((~b) & mask) : b;
    s    = a + bb + m;
    sa   = (a >> (w - 1)) & 1;
    sb   = (bb >> (w - 1)) & 1;
    sr   = (s >> (w - 1)) & 1;
    model = {((sa == sb) && (sr != sa)) ? 1'b1 : 1'b0, 9'(s & ((mask << 1) | 1))};
  endfunction

  // 8-bit output monitor.
  always @(negedge clk) begin
    if (done8) begin
      if (sb8.size() == 0) begin
        chk("spurious_done8", 1, 0);
      end else begin
        chk("ans8", ans8, sb8[0].ans);
        chk("ovf8", ovf8, sb8[0].ovf);
        chk("lat8", cyc, sb8[0].cyc);
        chk("busy_len8", run8, 4);
        void'(sb8.pop_front());
      end
      run8 <= 0;
    end else if (busy8) begin
      run8 <= run8 + 1;
    end else begin
      run8 <= 0;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : sw
    localparam int DG = 1 << g;
    logic       bsy, dn, ov;
    logic [4:0] an;
    int         run = 0;

    serial_addsub #(.WIDTH(4), .DIGIT(DG)) u_dut4 (
      .clk(clk), .rst(rst), .start(s4), .mode(m4), .bit1(a4), .bit2(b4),
      .busy(bsy), .done(dn), .final_answer(an), .overflow(ov)
    );

    // 4-bit output monitor for this DIGIT.
    always @(negedge clk) begin
      if (dn) begin
        if (q4[g].size() == 0) begin
          chk($sformatf("spurious_done4_d%0d", DG), 1, 0);
        end else begin
          chk($sformatf("ans4_d%0d", DG), an, q4[g][0].ans);
          chk($sformatf("ovf4_d%0d", DG), ov, q4[g][0].ovf);
          chk($sformatf("lat4_d%0d", DG), cyc, q4[g][0].cyc);
          chk($sformatf("busy_len4_d%0d", DG), run, 4 / DG);
          void'(q4[g].pop_front());
        end
        run <= 0;
      end else if (bsy) begin
        run <= run + 1;
      end else begin
        run <= 0;
      end
    end
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic m,
                     input logic [8:0] ea, input logic eo);
    @(negedge clk);
    s8 = 1'b1; a8 = a; b8 = b; m8 = m;
    @(posedge clk); #1;
    sb8.push_back('{ea, eo, cyc + 4});
    @(negedge clk);
    s8 = 1'b0;
  endtask

  task automatic drain8();
    int t = 0;
    while (sb8.size() != 0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    if (sb8.size() != 0) begin
      chk("drain8_timeout", sb8.size(), 0);
      sb8.delete();
    end
  endtask

  initial begin
    logic [9:0] r;
    rst = 1'b1; s8 = 1'b0; m8 = 1'b0; a8 = '0; b8 = '0;
    s4 = 1'b0; m4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_ans", ans8, 0);
    chk("rst_ovf", ovf8, 0);
    rst = 1'b0;

    op8(8'h0F, 8'h01, 1'b0, 9'h010, 1'b0); drain8();
    op8(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0); drain8();
    op8(8'h7F, 8'h01, 1'b0, 9'h080, 1'b1); drain8();
    op8(8'h05, 8'h07, 1'b1, 9'h0FE, 1'b0); drain8();
    op8(8'h80, 8'h01, 1'b1, 9'h17F, 1'b1); drain8();

    // Back-to-back: start held through DONE, second operands already waiting.
    @(negedge clk);
    s8 = 1'b1; a8 = 8'h10; b8 = 8'h20; m8 = 1'b0;
    @(posedge clk); #1;
    sb8.push_back('{9'h030, 1'b0, cyc + 4});
    a8 = 8'h01; b8 = 8'h01;
    repeat (5) @(posedge clk);
    #1;
    sb8.push_back('{9'h002, 1'b0, cyc + 4});
    s8 = 1'b0;
    drain8();

    // Start with different operands during RUN must be ignored.
    op8(8'h12, 8'h34, 1'b0, 9'h046, 1'b0);
    s8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; m8 = 1'b1;
    repeat (2) @(negedge clk);
    s8 = 1'b0;
    drain8();

    // Reset in the second RUN cycle discards the operation.
    op8(8'h0F, 8'h01, 1'b0, 9'h010, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    sb8.delete();
    chk("midrst_busy", busy8, 0);
    chk("midrst_done", done8, 0);
    chk("midrst_ans", ans8, 0);
    chk("midrst_ovf", ovf8, 0);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    op8(8'h80, 8'h80, 1'b0, 9'h100, 1'b1); drain8();

    // Exhaustive 4-bit sweep across all three DIGIT settings.
    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          int t;
          @(negedge clk);
          s4 = 1'b1; m4 = m[0]; a4 = a[3:0]; b4 = b[3:0];
          @(posedge clk); #1;
          r = model(4, a, b, m);
          for (int g = 0; g < 3; g++) begin
            q4[g].push_back('{r[8:0], r[9], cyc + (4 >> g)});
          end
          @(negedge clk);
          s4 = 1'b0;
          t = 0;
          while ((q4[0].size() + q4[1].size() + q4[2].size()) != 0 && t < 12) begin
            @(posedge clk);
            t++;
          end
          if ((q4[0].size() + q4[1].size() + q4[2].size()) != 0) begin
            chk("sweep_timeout", q4[0].size() + q4[1].size() + q4[2].size(), 0);
            for (int g = 0; g < 3; g++) q4[g].delete();
          end
        end
      end
    end

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
